mux_n_pipe: RTL and testbench

- Parametrised successor to the 32-bit 2:1 datapath mux. Selects one of N WIDTH-bit operands by binary select and registers the result behind a valid/ready handshake.
- Includes a one-entry skid buffer so in_ready has no combinational path from out_ready.
- Used between pipeline stages (e.g. forwarding/writeback select) where the stage can stall or be flushed.

---
 rtl/mux_n_pipe.sv | 112 +++++++++++
 tb/tb_mux_n_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_n_pipe
// Brief    : N:1 operand select, registered behind valid/ready with a skid.
// Revision : 1.0 - initial release
// ============================================================================
module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] w_cap_data;
    logic             w_cap_err;

    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_err_q,  m_err_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             s_err_q,  s_err_d;
    logic             s_valid_q, s_valid_d;

    logic w_acc;
    logic w_drn;

    // Out-of-range selects yield zero data with the error flag set.
    always_comb begin
        w_cap_data = '0;
        w_cap_err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                w_cap_data = in_data[k*WIDTH +: WIDTH];
                w_cap_err  = 1'b0;
            end
        end
    end

    assign w_acc = in_valid && !s_valid_q;
    assign w_drn = m_valid_q && out_ready;

    always_comb begin
        m_data_d  = m_data_q;
        m_err_d   = m_err_q;
        m_valid_d = m_valid_q;
        s_data_d  = s_data_q;
        s_err_d   = s_err_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q) begin
            if (w_acc) begin
                m_data_d  = w_cap_data;
                m_err_d   = w_cap_err;
                m_valid_d = 1'b1;
            end
        end else if (w_drn) begin
            if (s_valid_q) begin
                m_data_d  = s_data_q;
                m_err_d   = s_err_q;
                s_valid_d = 1'b0;
            end else if (w_acc) begin
                m_data_d  = w_cap_data;
                m_err_d   = w_cap_err;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (w_acc) begin
            // Downstream stalled: park the new item in the skid slot.
            s_data_d  = w_cap_data;
            s_err_d   = w_cap_err;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_q  <= '0;
            m_err_q   <= 1'b0;
            m_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_err_q   <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_data_q  <= m_data_d;
            m_err_q   <= m_err_d;
            m_valid_q <= m_valid_d;
            s_data_q  <= s_data_d;
            s_err_q   <= s_err_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign in_ready  = !s_valid_q;
    assign out_data  = m_data_q;
    assign out_err   = m_err_q;
    assign out_valid = m_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_n_pipe
// Brief    : Directed self-checking bench for mux_n_pipe (N=4 and N=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_n_pipe;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [4*WIDTH-1:0] in_data4;
    logic [1:0]       sel4;
    logic             in_valid4, in_ready4, flush4;
    logic [WIDTH-1:0] out_data4;
    logic             out_err4, out_valid4, out_ready4;

    logic [3*WIDTH-1:0] in_data3;
    logic [1:0]       sel3;
    logic             in_valid3, in_ready3, flush3;
    logic [WIDTH-1:0] out_data3;
    logic             out_err3, out_valid3, out_ready3;

    int checks = 0;
    int errors = 0;

    mux_n_pipe #(.WIDTH(WIDTH), .N(4), .SEL_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .sel(sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .flush(flush4),
        .out_data(out_data4), .out_err(out_err4), .out_valid(out_valid4),
        .out_ready(out_ready4)
    );

    mux_n_pipe #(.WIDTH(WIDTH), .N(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .out_data(out_data3), .out_err(out_err3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_data4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        sel4 = 2'd0; in_valid4 = 1'b0; flush4 = 1'b0; out_ready4 = 1'b1;
        in_data3 = {32'h33333333, 32'h22222222, 32'h11111111};
        sel3 = 2'd0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, out_valid4}, 32'd0);
        chk("rst_out_data",  out_data4, 32'd0);
        chk("rst_out_err",   {31'd0, out_err4}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready4}, 32'd1);
        rst = 1'b0;
        step();

        // Streaming: sel 0..3 back to back.
        in_valid4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            step();
            chk("stream_data",  out_data4, {4{4'(i + 1), 4'(i + 1)}});
            chk("stream_valid", {31'd0, out_valid4}, 32'd1);
            chk("stream_ready", {31'd0, in_ready4}, 32'd1);
        end
        in_valid4 = 1'b0;
        step();
        chk("stream_empty", {31'd0, out_valid4}, 32'd0);

        // Stall: A into M, B into skid.
        out_ready4 = 1'b0;
        in_valid4 = 1'b1;
        sel4 = 2'd0;
        in_data4[31:0] = 32'hA5A5A5A5;
        step();
        chk("stall_a_data", out_data4, 32'hA5A5A5A5);
        chk("stall_a_ready", {31'd0, in_ready4}, 32'd1);
        in_data4[31:0] = 32'h5A5A5A5A;
        step();
        in_valid4 = 1'b0;
        chk("stall_b_ready", {31'd0, in_ready4}, 32'd0);
        chk("stall_hold_a", out_data4, 32'hA5A5A5A5);
        step();
        chk("stall_hold_a2", out_data4, 32'hA5A5A5A5);
        chk("stall_hold_v", {31'd0, out_valid4}, 32'd1);
        out_ready4 = 1'b1;
        step();
        chk("drain_b_data", out_data4, 32'h5A5A5A5A);
        chk("drain_b_valid", {31'd0, out_valid4}, 32'd1);
        chk("drain_ready_back", {31'd0, in_ready4}, 32'd1);
        step();
        chk("drain_empty", {31'd0, out_valid4}, 32'd0);

        // Flush with M and S full and an input offered.
        out_ready4 = 1'b0;
        in_valid4 = 1'b1;
        in_data4[31:0] = 32'hC0C0C0C0;
        step();
        in_data4[31:0] = 32'hD0D0D0D0;
        step();
        chk("flush_pre_ready", {31'd0, in_ready4}, 32'd0);
        flush4 = 1'b1;
        sel4 = 2'd2;
        step();
        flush4 = 1'b0;
        in_valid4 = 1'b0;
        chk("flush_valid", {31'd0, out_valid4}, 32'd0);
        chk("flush_ready", {31'd0, in_ready4}, 32'd1);
        out_ready4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_nothing", {31'd0, out_valid4}, 32'd0);
        end

        // Flush while empty with an accepted transfer: it is dropped.
        in_valid4 = 1'b1;
        flush4 = 1'b1;
        step();
        flush4 = 1'b0;
        in_valid4 = 1'b0;
        chk("flush_acc_drop", {31'd0, out_valid4}, 32'd0);
        step();
        chk("flush_acc_drop2", {31'd0, out_valid4}, 32'd0);

        // Reset mid-stall.
        out_ready4 = 1'b0;
        in_valid4 = 1'b1;
        sel4 = 2'd0;
        in_data4[31:0] = 32'hE0E0E0E0;
        step();
        in_data4[31:0] = 32'hF0F0F0F0;
        step();
        in_valid4 = 1'b0;
        chk("mid_full", {31'd0, in_ready4}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid4}, 32'd0);
        chk("mid_rst_data",  out_data4, 32'd0);
        chk("mid_rst_err",   {31'd0, out_err4}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready4}, 32'd1);
        #1;
        rst = 1'b0;
        in_data4[31:0] = 32'h12345678;
        in_valid4 = 1'b1;
        out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        chk("post_rst_data",  out_data4, 32'h12345678);
        chk("post_rst_valid", {31'd0, out_valid4}, 32'd1);
        step();
        chk("post_rst_empty", {31'd0, out_valid4}, 32'd0);

        // Out-of-range select on the N=3 instance.
        in_valid3 = 1'b1;
        sel3 = 2'd3;
        step();
        chk("oor_data", out_data3, 32'h00000000);
        chk("oor_err",  {31'd0, out_err3}, 32'd1);
        chk("oor_valid", {31'd0, out_valid3}, 32'd1);
        sel3 = 2'd1;
        step();
        in_valid3 = 1'b0;
        chk("inr_data", out_data3, 32'h22222222);
        chk("inr_err",  {31'd0, out_err3}, 32'd0);
        step();
        chk("n3_empty", {31'd0, out_valid3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
